// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the pipelined CPU blocks.
//   - opcode constants (top nibble of a 16-bit instruction)
//   - fetch-stage state encoding
//   - default PC increment per instruction
package cpu_pkg;

  localparam int PC_STEP_DEFAULT = 2;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_BRA = 4'hC;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FS_REQ    = 2'd0,
    FS_WAIT   = 2'd1,
    FS_HOLD   = 2'd2,
    FS_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: modulo-2^ADDR_W adder that advances an address by STEP.
// Ports:
//   addr_i  in  ADDR_W  address to advance
//   sum_o   out ADDR_W  addr_i + STEP, wrapping at 2^ADDR_W
module pc_incrementer #(
  parameter int ADDR_W = 16,
  parameter int STEP   = 2
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] sum_o
);

  assign sum_o = addr_i + ADDR_W'(STEP);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, keeps at most one
// request outstanding to a variable-latency instruction memory, buffers a
// response that arrives under stall, and stops fetching after HLT until a
// redirect arrives.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         one-cycle request pulse and its address
//   imem_valid/imem_rdata      one-cycle response strobe and instruction
//   stall, flush               hazard controls for the IF/ID register
//   redirect_valid/redirect_pc new PC from branch resolution
//   pc                         next fetch address
//   ifid_valid/instr/pc/pc_next IF/ID pipeline register contents
//   fetch_halted               HLT delivered, no further requests
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter int              INSTR_W    = 16,
  parameter int              PC_STEP    = PC_STEP_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HLT_OPCODE = OP_HLT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic               fetch_halted
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               drop_pending_q, drop_pending_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0]  ifid_pc_next_q, ifid_pc_next_d;

  logic [ADDR_W-1:0]  pc_plus_step;
  logic [ADDR_W-1:0]  req_pc_plus_step;
  logic               new_valid;
  logic [INSTR_W-1:0] new_instr;
  logic               resp_is_hlt;
  logic               skid_is_hlt;

  pc_incrementer #(.ADDR_W(ADDR_W), .STEP(PC_STEP)) u_pc_inc (
    .addr_i (pc_q),
    .sum_o  (pc_plus_step)
  );

  pc_incrementer #(.ADDR_W(ADDR_W), .STEP(PC_STEP)) u_ifid_inc (
    .addr_i (req_pc_q),
    .sum_o  (req_pc_plus_step)
  );

  assign resp_is_hlt = (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE);
  assign skid_is_hlt = (skid_instr_q[INSTR_W-1 -: 4] == HLT_OPCODE);

  // rst_n gates the request so nothing is presented while reset is held,
  // yet the first request goes out in the very cycle reset is released.
  assign imem_req     = rst_n && (state_q == FS_REQ) && !drop_pending_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign fetch_halted = (state_q == FS_HALTED);
  assign ifid_valid   = ifid_valid_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_pc_next = ifid_pc_next_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    drop_pending_d = drop_pending_q;
    skid_instr_d   = skid_instr_q;
    new_valid      = 1'b0;
    new_instr      = imem_rdata;

    case (state_q)
      FS_REQ: begin
        req_pc_d = pc_q;
        state_d  = FS_WAIT;
        if (redirect_valid) begin
          // The request just issued is now stale; its response must be eaten.
          pc_d           = redirect_pc;
          drop_pending_d = 1'b1;
        end else begin
          pc_d = pc_plus_step;
        end
      end

      FS_WAIT: begin
        if (imem_valid) begin
          if (redirect_valid || drop_pending_q) begin
            drop_pending_d = 1'b0;
            state_d        = FS_REQ;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else if (stall) begin
            skid_instr_d = imem_rdata;
            state_d      = FS_HOLD;
          end else begin
            new_valid = 1'b1;
            new_instr = imem_rdata;
            // A flushed instruction was never delivered, so it cannot halt.
            state_d   = (resp_is_hlt && !flush) ? FS_HALTED : FS_REQ;
          end
        end else if (redirect_valid) begin
          pc_d           = redirect_pc;
          drop_pending_d = 1'b1;
        end
      end

      FS_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FS_REQ;
        end else if (!stall) begin
          new_valid = 1'b1;
          new_instr = skid_instr_q;
          state_d   = (skid_is_hlt && !flush) ? FS_HALTED : FS_REQ;
        end
      end

      FS_HALTED: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FS_REQ;
        end
      end

      default: state_d = FS_REQ;
    endcase
  end

  // IF/ID: flush beats stall; without either, a cycle with no new
  // instruction becomes a bubble. req_pc_q stays frozen through HOLD, so it
  // still names the skid entry's address when the skid drains.
  always_comb begin
    ifid_valid_d   = ifid_valid_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pc_next_d = ifid_pc_next_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (new_valid) begin
      ifid_valid_d   = 1'b1;
      ifid_instr_d   = new_instr;
      ifid_pc_d      = req_pc_q;
      ifid_pc_next_d = req_pc_plus_step;
    end else begin
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FS_REQ;
      pc_q           <= RESET_PC;
      req_pc_q       <= '0;
      drop_pending_q <= 1'b0;
      skid_instr_q   <= '0;
      ifid_valid_q   <= 1'b0;
      ifid_instr_q   <= '0;
      ifid_pc_q      <= '0;
      ifid_pc_next_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      req_pc_q       <= req_pc_d;
      drop_pending_q <= drop_pending_d;
      skid_instr_q   <= skid_instr_d;
      ifid_valid_q   <= ifid_valid_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pc_next_q <= ifid_pc_next_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined successor of the single-cycle `cpu` top. It owns the PC and issues requests to a variable-latency instruction memory, one outstanding request at a time. It accepts redirects from branches, stalls and flushes from the hazard logic, and detects HLT at fetch. It delivers fetched instructions, their PC and PC+step (for PCS) into the IF/ID pipeline register.

## Interface
- `ADDR_W`, 16, PC/address width
- `INSTR_W`, 16, instruction width
- `PC_STEP`, 2, byte increment per instruction
- `RESET_PC`, 0, PC loaded on reset
- `HLT_OPCODE`, 4'hF, value of instr[INSTR_W-1 -: 4] that halts fetch

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  one-cycle request pulse; memory samples it with `imem_addr`
- `imem_addr`  out  ADDR_W  fetch address, valid while `imem_req`=1
- `imem_valid`  in  1  response strobe, one cycle, ≥1 cycle after request
- `imem_rdata`  in  INSTR_W  instruction, valid with `imem_valid`
- `stall`  in  1  hold IF/ID contents
- `flush`  in  1  squash IF/ID (invalidate)
- `redirect_valid`  in  1  load new PC
- `redirect_pc`  in  ADDR_W  target PC
- `pc`  out  ADDR_W  next fetch address (PC register)
- `ifid_valid`  out  1  IF/ID holds a live instruction
- `ifid_instr`  out  INSTR_W  IF/ID instruction
- `ifid_pc`  out  ADDR_W  address of `ifid_instr`
- `ifid_pc_next`  out  ADDR_W  `ifid_pc`+PC_STEP (PCS write data)
- `fetch_halted`  out  1  HLT fetched, no further requests

## Operation
- States: REQ, WAIT, HOLD, HALTED.
  - REQ: `imem_req`=1, `imem_addr`=`pc`, `req_pc`<=`pc`, `pc`<=`pc`+PC_STEP; go to WAIT.
  - WAIT: wait for `imem_valid`.
    - If `!stall`, load IF/ID, then go to REQ (or HALTED if the opcode matches HLT_OPCODE).
    - If `stall`, capture the response into the skid buffer and go to HOLD.
  - HOLD: when `stall` drops, move the skid buffer into IF/ID, then go to REQ or HALTED (HLT rule as in WAIT).
  - HALTED: no requests; `fetch_halted`=1; leave only on redirect.
- IF/ID update rules, in priority order:
  - `flush` → `ifid_valid`<=0 (beats `stall`).
  - `stall` → hold all IF/ID fields.
  - New instruction available → load it with `ifid_valid`<=1.
  - Otherwise → `ifid_valid`<=0 (bubble).
- Redirect (priority over stall and over any state):
  - `pc`<=`redirect_pc`.
  - Skid buffer is dropped.
  - If a request is outstanding (in WAIT, without `imem_valid` this cycle), set `drop_pending`. The next `imem_valid` is discarded, then go to REQ.
  - Otherwise go to REQ next cycle.
  - A redirect in the same cycle as `imem_valid` discards that response.
  - A redirect in REQ: the issued request is outstanding, so set `drop_pending`.
- HLT detection uses the delivered instruction only; discarded responses never halt.
- Arithmetic: PC+PC_STEP is modulo 2^ADDR_W (0xFFFE+2 → 0x0000 at defaults). `ifid_pc_next` wraps identically.

## Timing
- Reset values:
  - `pc`=RESET_PC, state=REQ, `imem_req`=0 during reset.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc`=0, `ifid_pc_next`=0.
  - `fetch_halted`=0, `drop_pending`=0.
- The first request is issued in the first cycle after `rst_n` deasserts.
- Memory latency L≥1: request in cycle t, `imem_valid` in t+L, IF/ID valid from t+L+1, next request at t+L+1.
- Throughput is one instruction per L+1 cycles.
- Redirect in cycle r with nothing outstanding: request to the target at r+1.
- `imem_req` is never high while a request is outstanding or `drop_pending`=1.
- `rst_n` low mid-request: all state clears immediately. A late `imem_valid` after reset must be ignored until the first request issues. Memory must not deliver responses for pre-reset requests once the first post-reset request is issued.

## Structure
- Shared `cpu_pkg`: opcode constants (including `HLT_OPCODE`), fetch state enum, `PC_STEP` default.
- One sub-module, `pc_incrementer`: ADDR_W modulo adder, reused for `pc`+step and `ifid_pc_next`.
- Skid buffer and IF/ID register stay inline.

## Test plan
- Reset → `pc`=0x0000, `ifid_valid`=0; first `imem_req` at 0x0000 one cycle after release.
- L=3 sequential fetch of 0x0000/0x0002/0x0004 → IF/ID valid every 4 cycles, `ifid_pc_next`=0x0002/0x0004/0x0006.
- `stall` held 5 cycles across the response at 0x0002 → IF/ID keeps 0x0000. The 0x0002 instruction appears the cycle after `stall` drops; no request is issued during HOLD.
- Redirect to 0x0100 while 0x0004 is in flight → 0x0004 is never delivered; next `imem_addr`=0x0100.
- `flush` and `stall` in the same cycle → `ifid_valid`=0 the next cycle.
- Fetch HLT (0xF000) at 0x0006 → delivered in IF/ID, `fetch_halted`=1, no requests for 20 cycles. Redirect to 0x0010 → fetch resumes.
- RESET_PC=0xFFFE → second request at 0x0000, `ifid_pc_next`=0x0000.
